usfft64_result_capture: RTL and testbench

//   Receiver for the USFFT64 result side (RDY, OVF1, OVF2, ADDR, DOR, DOI).

---
 rtl/usfft64_result_capture.sv | 170 +++++++++++++++++
 tb/tb_usfft64_result_capture.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usfft64_result_capture.sv
// usfft64_result_capture: receives one 64-point USFFT64 result frame into a
// local buffer and drains it in natural bin order over a valid/ready stream.
// Tracks per-frame overflow and counts frames dropped while busy.
// Optional build macro: CAP_ADDR_CHECK_EN (buffer is written at the internal
// count and ADDR is checked against it; otherwise ADDR is the write index).
module usfft64_result_capture #(
  parameter int unsigned DW     = 19,
  parameter int unsigned AW     = 6,
  parameter int unsigned DROP_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ED,
  input  logic              RDY,
  input  logic              OVF1,
  input  logic              OVF2,
  input  logic [AW-1:0]     ADDR,
  input  logic [DW-1:0]     DOR,
  input  logic [DW-1:0]     DOI,
  output logic              M_VALID,
  input  logic              M_READY,
  output logic [2*DW-1:0]   M_DATA,
  output logic [AW-1:0]     M_INDEX,
  output logic              M_LAST,
  output logic [1:0]        FRAME_OVF,
  output logic [DROP_W-1:0] DROP_CNT,
  output logic              BUSY,
  output logic              ADDR_ERR
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN
  } state_t;

  state_t              state_q;
  logic [AW:0]         cnt_q;
  logic [AW:0]         rd_ptr_q;
  logic [1:0]          ovf_acc_q;
  logic [1:0]          frame_ovf_q;
  logic [DROP_W-1:0]   drop_cnt_q;
  logic                addr_err_q;

  logic [2*DW-1:0]     buf_mem [DEPTH];

  logic                s1_valid_q;
  logic [AW-1:0]       s1_idx_q;
  logic [2*DW-1:0]     s1_data_q;

  logic                out_valid_q;
  logic [2*DW-1:0]     out_data_q;
  logic [AW-1:0]       out_idx_q;
  logic                out_last_q;

  logic                frame_start;
  logic                cap_word;
  logic                last_cap;
  logic                drop_evt;
  logic                hs;
  logic                s1_move;
  logic                fetch_en;
  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic                addr_bad;

  // Decode frame events, write port and drain pipeline advance conditions.
  always_comb begin
    frame_start = ED && RDY && (state_q != S_DRAIN);
    cap_word    = (state_q == S_CAPTURE) && ED && !RDY;
    last_cap    = cap_word && (cnt_q == LAST_CNT);
    drop_evt    = ED && RDY && (state_q != S_IDLE);
    hs          = out_valid_q && M_READY;
    s1_move     = s1_valid_q && (!out_valid_q || M_READY);
    // Word 0 is fetched on the final capture cycle so the first word is
    // presented two cycles after it; the skid stage keeps 1 word/cycle.
    fetch_en    = (last_cap || (state_q == S_DRAIN)) && !rd_ptr_q[AW] &&
                  (!s1_valid_q || s1_move);
    wr_en       = frame_start || cap_word;
`ifdef CAP_ADDR_CHECK_EN
    wr_idx      = frame_start ? '0 : cnt_q[AW-1:0];
    addr_bad    = (ADDR != wr_idx);
`else
    wr_idx      = ADDR;
    addr_bad    = 1'b0;
`endif
  end

  // Frame buffer write port and registered read into the prefetch stage.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      buf_mem[wr_idx] <= {DOR, DOI};
    end
    if (fetch_en) begin
      s1_data_q <= buf_mem[rd_ptr_q[AW-1:0]];
    end
  end

  // Capture/drain FSM, overflow and drop bookkeeping, output registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      ovf_acc_q   <= '0;
      frame_ovf_q <= '0;
      drop_cnt_q  <= '0;
      addr_err_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      if (drop_evt && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end

      if (frame_start) begin
        state_q     <= S_CAPTURE;
        cnt_q       <= (AW+1)'(1);
        rd_ptr_q    <= '0;
        ovf_acc_q   <= {OVF2, OVF1};
        frame_ovf_q <= '0;
        addr_err_q  <= addr_bad;
      end else if (cap_word) begin
        cnt_q      <= cnt_q + (AW+1)'(1);
        ovf_acc_q  <= ovf_acc_q | {OVF2, OVF1};
        addr_err_q <= addr_err_q | addr_bad;
        if (last_cap) begin
          state_q     <= S_DRAIN;
          frame_ovf_q <= ovf_acc_q | {OVF2, OVF1};
        end
      end else if ((state_q == S_DRAIN) && hs && out_last_q) begin
        state_q <= S_IDLE;
      end

      if (fetch_en) begin
        s1_valid_q <= 1'b1;
        s1_idx_q   <= rd_ptr_q[AW-1:0];
        rd_ptr_q   <= rd_ptr_q + (AW+1)'(1);
      end else if (s1_move) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_move) begin
        out_valid_q <= 1'b1;
        out_data_q  <= s1_data_q;
        out_idx_q   <= s1_idx_q;
        out_last_q  <= (s1_idx_q == '1);
      end else if (hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign M_VALID   = out_valid_q;
  assign M_DATA    = out_data_q;
  assign M_INDEX   = out_idx_q;
  assign M_LAST    = out_last_q;
  assign FRAME_OVF = frame_ovf_q;
  assign DROP_CNT  = drop_cnt_q;
  assign BUSY      = (state_q != S_IDLE);
  assign ADDR_ERR  = addr_err_q;

endmodule

// File: tb/tb_usfft64_result_capture.sv
// Testbench for usfft64_result_capture: table of frame scenarios, hand-written
// abort/drop/reset sequences and randomized frames checked against a simple
// array model of the captured frame.
`timescale 1ns/1ps
module tb_usfft64_result_capture;

  localparam int DW     = 19;
  localparam int AW     = 6;
  localparam int DROP_W = 8;
  localparam int N      = 64;

  logic              CLK = 1'b0;
  logic              RST, ED, RDY, OVF1, OVF2, M_READY;
  logic [AW-1:0]     ADDR;
  logic [DW-1:0]     DOR, DOI;
  logic              M_VALID, M_LAST, BUSY, ADDR_ERR;
  logic [2*DW-1:0]   M_DATA;
  logic [AW-1:0]     M_INDEX;
  logic [1:0]        FRAME_OVF;
  logic [DROP_W-1:0] DROP_CNT;

  usfft64_result_capture #(.DW(DW), .AW(AW), .DROP_W(DROP_W)) dut (
    .CLK(CLK), .RST(RST), .ED(ED), .RDY(RDY), .OVF1(OVF1), .OVF2(OVF2),
    .ADDR(ADDR), .DOR(DOR), .DOI(DOI),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_INDEX(M_INDEX),
    .M_LAST(M_LAST), .FRAME_OVF(FRAME_OVF), .DROP_CNT(DROP_CNT),
    .BUSY(BUSY), .ADDR_ERR(ADDR_ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    logic            v, r, last, rst;
    logic [2*DW-1:0] d;
    logic [AW-1:0]   idx;
    logic [1:0]      ovf;
    int              cyc;
  } samp_t;
  samp_t sq[$];

  // Output observer: one sample per cycle, away from the active edge.
  always @(negedge CLK) begin
    samp_t s;
    s.v = M_VALID; s.r = M_READY; s.last = M_LAST; s.rst = RST;
    s.d = M_DATA;  s.idx = M_INDEX; s.ovf = FRAME_OVF; s.cyc = cyc;
    sq.push_back(s);
  end

  int vectors = 0;
  int miscompares = 0;
  int exp_drop = 0;
  logic exp_aerr = 1'b0;
  int last_cap_cyc = 0;

  logic [DW-1:0] fr_r [N];
  logic [DW-1:0] fr_i [N];
  logic          fr_o1[N];
  logic          fr_o2[N];

  typedef struct {
    int         data_mode;  // 0: DOR=k, DOI=-k   1: random
    int         gap_mode;   // 0: none  1: ED=0 between words  2: random gaps
    int         rdy_mode;   // 0: always  1: 1,0,0 repeating  2: random
    int         o1_k;       // word carrying OVF1 (-1 none)
    int         o2_k;       // word carrying OVF2 (-1 none)
    logic [1:0] exp_ovf;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic ed, input logic rdy, input logic o1, input logic o2,
                       input logic [AW-1:0] a, input logic [DW-1:0] r, input logic [DW-1:0] i);
    @(posedge CLK); #1;
    ED = ed; RDY = rdy; OVF1 = o1; OVF2 = o2; ADDR = a; DOR = r; DOI = i;
  endtask

  task automatic fill_frame(input int mode, input int o1k, input int o2k);
    for (int k = 0; k < N; k++) begin
      if (mode == 0) begin
        fr_r[k] = DW'(k);
        fr_i[k] = DW'(-k);
      end else begin
        fr_r[k] = DW'($urandom);
        fr_i[k] = DW'($urandom);
      end
      if (mode == 2) begin
        fr_o1[k] = ($urandom_range(0, 39) == 0);
        fr_o2[k] = ($urandom_range(0, 39) == 0);
      end else begin
        fr_o1[k] = (k == o1k);
        fr_o2[k] = (k == o2k);
      end
    end
  endtask

  function automatic logic [1:0] ovf_model();
    logic [1:0] acc = 2'b00;
    for (int k = 0; k < N; k++) acc = acc | {fr_o2[k], fr_o1[k]};
    return acc;
  endfunction

  // Present the frame held in fr_* ; gap cycles carry junk and set OVF flags.
  task automatic send_frame(input int gap_mode, input int bad_addr_k);
    for (int k = 0; k < N; k++) begin
      int ngap;
      logic [AW-1:0] a;
      ngap = (gap_mode == 1) ? ((k > 0) ? 1 : 0) :
             (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < ngap; g++)
        drive(1'b0, 1'b0, 1'b1, 1'b1, AW'($urandom), DW'($urandom), DW'($urandom));
      a = AW'(k);
      if (k == bad_addr_k) a = AW'(k + 1);
      drive(1'b1, (k == 0), fr_o1[k], fr_o2[k], a, fr_r[k], fr_i[k]);
    end
    last_cap_cyc = cyc;
  endtask

  // Run the drain with the chosen M_READY pattern, optionally injecting a new
  // frame start after inj_at words, then check every word and the end state.
  task automatic drain_check(input int rdy_mode, input int inj_at, input logic [1:0] exp_ovf);
    int base, t, ph, hs_n, first;
    bit injected;
    base = sq.size(); t = 0; ph = 0; hs_n = 0; first = -1; injected = 0;
    while (hs_n < N && t < 600) begin
      if (inj_at >= 0 && !injected && hs_n >= inj_at) begin
        injected = 1;
        if (exp_drop < 255) exp_drop++;
        drive(1'b1, 1'b1, 1'b1, 1'b1, '0, DW'($urandom), DW'($urandom));
      end else begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      case (rdy_mode)
        0:       M_READY = 1'b1;
        1:       M_READY = (ph % 3 == 0);
        default: M_READY = 1'($urandom_range(0, 1));
      endcase
      ph++;
      @(negedge CLK); #1;
      t++;
      if (sq[sq.size()-1].v && sq[sq.size()-1].r) hs_n++;
    end
    if (t >= 600) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got %0d words, required %0d", hs_n, N);
    end
    @(negedge CLK); #1;
    chk("end_m_valid", 64'(M_VALID), 64'(0));
    chk("end_busy", 64'(BUSY), 64'(0));
    chk("drop_cnt", 64'(DROP_CNT), 64'(exp_drop));
    chk("addr_err", 64'(ADDR_ERR), 64'(exp_aerr));

    hs_n = 0;
    for (int j = base; j < sq.size(); j++) begin
      if (sq[j].v && first < 0) first = sq[j].cyc;
      if (j > base && sq[j-1].v && !sq[j-1].r && !sq[j-1].rst) begin
        vectors++;
        if (!sq[j].v || sq[j].d !== sq[j-1].d || sq[j].idx !== sq[j-1].idx || sq[j].last !== sq[j-1].last) begin
          miscompares++;
          $display("FAIL stall_hold cyc=%0d: got v=%0b d=%h idx=%0d, required v=1 d=%h idx=%0d",
                   sq[j].cyc, sq[j].v, sq[j].d, sq[j].idx, sq[j-1].d, sq[j-1].idx);
        end
      end
      if (sq[j].v && sq[j].r) begin
        if (hs_n < N) begin
          logic [2*DW-1:0] ed;
          bit bad;
          ed = {fr_r[hs_n], fr_i[hs_n]};
          bad = (sq[j].idx !== AW'(hs_n)) || (sq[j].d !== ed) ||
                (sq[j].last !== (hs_n == N-1)) || (sq[j].ovf !== exp_ovf) ||
                (rdy_mode == 0 && sq[j].cyc != first + hs_n);
          vectors++;
          if (bad) begin
            miscompares++;
            $display("FAIL word[%0d]: got idx=%0d data=%h last=%0b ovf=%b cyc=%0d, required idx=%0d data=%h last=%0b ovf=%b cyc=%0d",
                     hs_n, sq[j].idx, sq[j].d, sq[j].last, sq[j].ovf, sq[j].cyc,
                     hs_n, ed, (hs_n == N-1), exp_ovf, first + hs_n);
          end
        end
        hs_n++;
      end
    end
    chk("word_count", 64'(hs_n), 64'(N));
    chk("first_valid_latency", 64'(first - last_cap_cyc), 64'(2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, required finish before 1 ms");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    int   hs_cnt, t;
    tbl[0] = '{0, 0, 0, -1, -1, 2'b00};  // plain pass-through
    tbl[1] = '{0, 0, 1, -1, -1, 2'b00};  // backpressure 1,0,0
    tbl[2] = '{0, 1, 0, -1, -1, 2'b00};  // ED gaps
    tbl[3] = '{0, 0, 0, -1, 40, 2'b10};  // OVF2 at k=40
    tbl[4] = '{0, 0, 0, -1, -1, 2'b00};  // clean frame after overflow
    tbl[5] = '{1, 0, 2,  0, -1, 2'b01};  // OVF1 on the start word
    tbl[6] = '{1, 2, 2, 63,  5, 2'b11};  // both flags, random gaps/ready

    RST = 1'b1; ED = 1'b0; RDY = 1'b0; OVF1 = 1'b0; OVF2 = 1'b0;
    ADDR = '0; DOR = '0; DOI = '0; M_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_m_valid", 64'(M_VALID), 64'(0));
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_drop_cnt", 64'(DROP_CNT), 64'(0));
    chk("rst_frame_ovf", 64'(FRAME_OVF), 64'(0));
    chk("rst_addr_err", 64'(ADDR_ERR), 64'(0));
    chk("rst_m_last", 64'(M_LAST), 64'(0));
    chk("rst_m_index", 64'(M_INDEX), 64'(0));
    chk("rst_m_data", 64'(M_DATA), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    for (int v = 0; v < 7; v++) begin
      fill_frame(tbl[v].data_mode, tbl[v].o1_k, tbl[v].o2_k);
      send_frame(tbl[v].gap_mode, -1);
      drain_check(tbl[v].rdy_mode, -1, tbl[v].exp_ovf);
    end

    // New frame start during drain is dropped; then a capture is aborted at k=10.
    fill_frame(0, -1, -1);
    send_frame(0, -1);
    drain_check(0, 20, 2'b00);
    for (int k = 0; k < 10; k++)
      drive(1'b1, (k == 0), 1'b0, (k == 3), AW'(k), DW'($urandom), DW'($urandom));
    chk("drop_before_abort", 64'(DROP_CNT), 64'(1));
    exp_drop++;
    fill_frame(1, -1, -1);
    send_frame(0, -1);
    chk("drop_after_abort", 64'(DROP_CNT), 64'(exp_drop));
    drain_check(0, -1, 2'b00);

    // Reset in the middle of a drain.
    fill_frame(1, -1, -1);
    send_frame(0, -1);
    hs_cnt = 0; t = 0;
    while (hs_cnt < 30 && t < 200) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      M_READY = 1'b1;
      @(negedge CLK); #1;
      t++;
      if (sq[sq.size()-1].v && sq[sq.size()-1].r) hs_cnt++;
    end
    chk("pre_reset_words", 64'(hs_cnt), 64'(30));
    @(posedge CLK); #1; RST = 1'b1;
    @(posedge CLK); #1; RST = 1'b0;
    @(negedge CLK); #1;
    exp_drop = 0;
    chk("midrst_m_valid", 64'(M_VALID), 64'(0));
    chk("midrst_busy", 64'(BUSY), 64'(0));
    chk("midrst_drop_cnt", 64'(DROP_CNT), 64'(0));
    fill_frame(0, 7, -1);
    send_frame(0, -1);
    drain_check(0, -1, 2'b01);

`ifdef CAP_ADDR_CHECK_EN
    // ADDR=5 while the internal count is 4: flag set, data still at index 4.
    fill_frame(1, -1, -1);
    exp_aerr = 1'b1;
    send_frame(0, 4);
    drain_check(0, -1, 2'b00);
    exp_aerr = 1'b0;
    fill_frame(1, -1, -1);
    send_frame(0, -1);
    drain_check(0, -1, 2'b00);
`endif

    // Randomized frames against the array/OR model.
    for (int r = 0; r < 6; r++) begin
      int inj;
      fill_frame(2, -1, -1);
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 63)) : -1;
      send_frame(int'($urandom_range(0, 2)), -1);
      drain_check(int'($urandom_range(0, 2)), inj, ovf_model());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
